// File: rtl/bip_control_unit.sv
// BIP-I multi-cycle control unit.
// The unit sequences fetch, decode, an optional data-RAM read and execute for
// each instruction. It drives the PC load strobe, the accumulator and ALU
// muxes, and the data-RAM strobes, and it stops on HLT.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start_bip
// FETCH  | program ROM is reading pc_addr
// DECODE | ROM word is valid on instruction and is latched into IR
// MEMRD  | data-RAM read of the IR operand (LD/ADD/SUB only)
// EXEC   | retire: WrPC plus per-opcode accumulator/RAM strobes
// HALT   | absorbing stop state after HLT
module bip_control_unit #(
   parameter int AB  = 11,
   parameter int OPW = 5,
   parameter int CW  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_bip,
   input  logic [OPW+AB-1:0] instruction,
   input  logic [AB-1:0]     pc_addr,
   output logic [AB-1:0]     pc_next,
   output logic              WrPC,
   output logic [AB-1:0]     ram_addr,
   output logic              RdRam,
   output logic              WrRam,
   output logic [1:0]        SelA,
   output logic              SelB,
   output logic              Op,
   output logic              WrAcc,
   output logic              halted,
   output logic              illegal,
   output logic [CW-1:0]     instr_count
);

   localparam logic [OPW-1:0] OP_HLT  = OPW'(0);
   localparam logic [OPW-1:0] OP_STO  = OPW'(1);
   localparam logic [OPW-1:0] OP_LD   = OPW'(2);
   localparam logic [OPW-1:0] OP_LDI  = OPW'(3);
   localparam logic [OPW-1:0] OP_ADD  = OPW'(4);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(6);
   localparam logic [OPW-1:0] OP_SUBI = OPW'(7);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEMRD,
      S_EXEC,
      S_HALT
   } state_t;

   state_t              state, state_nxt;
   logic [OPW+AB-1:0]   ir;
   logic [OPW-1:0]      ir_op;
   logic [OPW-1:0]      in_op;

   assign ir_op    = ir[OPW+AB-1:AB];
   assign in_op    = instruction[OPW+AB-1:AB];
   assign ram_addr = ir[AB-1:0];
   assign halted   = (state == S_HALT);
   assign pc_next  = pc_addr + {{(AB-1){1'b0}}, 1'b1};

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Instruction register, loaded once per instruction in DECODE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 ir <= '0;
      else if (state == S_DECODE) ir <= instruction;
   end

   // Retire bookkeeping: count every executed instruction, flag undefined opcodes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_count <= '0;
         illegal     <= 1'b0;
      end else if (state == S_EXEC) begin
         instr_count <= instr_count + CW'(1);
         if (ir_op > OP_SUBI) illegal <= 1'b1;
      end
   end

   // Next state and strobes; strobes decode from state and IR only, never from instruction.
   always_comb begin
      state_nxt = state;
      WrPC      = 1'b0;
      RdRam     = 1'b0;
      WrRam     = 1'b0;
      SelA      = 2'd0;
      SelB      = 1'b0;
      Op        = 1'b0;
      WrAcc     = 1'b0;
      case (state)
         S_IDLE:   if (start_bip) state_nxt = S_FETCH;
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: begin
            if (in_op == OP_HLT)
               state_nxt = S_HALT;
            else if (in_op == OP_LD || in_op == OP_ADD || in_op == OP_SUB)
               state_nxt = S_MEMRD;
            else
               state_nxt = S_EXEC;
         end
         S_MEMRD: begin
            RdRam     = 1'b1;
            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            WrPC      = 1'b1;
            state_nxt = S_FETCH;
            case (ir_op)
               OP_STO:  WrRam = 1'b1;
               OP_LD:   begin WrAcc = 1'b1; SelA = 2'd2; end
               OP_LDI:  begin WrAcc = 1'b1; SelA = 2'd1; end
               OP_ADD:  WrAcc = 1'b1;
               OP_ADDI: begin WrAcc = 1'b1; SelB = 1'b1; end
               OP_SUB:  begin WrAcc = 1'b1; Op = 1'b1; end
               OP_SUBI: begin WrAcc = 1'b1; SelB = 1'b1; Op = 1'b1; end
               default: ;
            endcase
         end
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: models program ROM and PC around the unit and
// checks every cycle against a per-instruction expectation list.
module tb_bip_control_unit;

   localparam int AB  = 11;
   localparam int OPW = 5;
   localparam int CW  = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start_bip;
   logic [OPW+AB-1:0] instruction;
   logic [AB-1:0]     pc_addr;
   logic [AB-1:0]     pc_next;
   logic              WrPC;
   logic [AB-1:0]     ram_addr;
   logic              RdRam;
   logic              WrRam;
   logic [1:0]        SelA;
   logic              SelB;
   logic              Op;
   logic              WrAcc;
   logic              halted;
   logic              illegal;
   logic [CW-1:0]     instr_count;

   bip_control_unit #(.AB(AB), .OPW(OPW), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start_bip(start_bip), .instruction(instruction),
      .pc_addr(pc_addr), .pc_next(pc_next), .WrPC(WrPC), .ram_addr(ram_addr),
      .RdRam(RdRam), .WrRam(WrRam), .SelA(SelA), .SelB(SelB), .Op(Op),
      .WrAcc(WrAcc), .halted(halted), .illegal(illegal), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // Program ROM (1-cycle latency) and Program_Counter around the unit.
   logic [15:0] rom [0:2047];
   logic        pc_load;
   logic [10:0] pc_load_val;

   always @(posedge clk) begin
      if (pc_load)   pc_addr <= pc_load_val;
      else if (WrPC) pc_addr <= pc_next;
      instruction <= rom[pc_addr];
   end

   typedef struct packed {
      logic        wrpc;
      logic        rdram;
      logic        wrram;
      logic [1:0]  sela;
      logic        selb;
      logic        op;
      logic        wracc;
      logic        halted;
      logic        illegal;
      logic [15:0] cnt;
      logic [10:0] raddr;
      logic [10:0] pcn;
   } rec_t;

   rec_t        exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   // model state
   logic        m_ill;
   logic [15:0] m_cnt;
   logic [10:0] m_opnd;

   function automatic rec_t actual();
      rec_t r;
      r.wrpc = WrPC; r.rdram = RdRam; r.wrram = WrRam; r.sela = SelA;
      r.selb = SelB; r.op = Op; r.wracc = WrAcc; r.halted = halted;
      r.illegal = illegal; r.cnt = instr_count; r.raddr = ram_addr; r.pcn = pc_next;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, expv);
      end
   endtask

   // Expand one instruction at address p into its expected per-cycle outputs.
   task automatic push_instr(input logic [10:0] p, input bit abort, output bit stop);
      logic [15:0] w;
      logic [4:0]  o;
      logic [10:0] a;
      rec_t        base, r;
      w    = rom[p];
      o    = w[15:11];
      a    = w[10:0];
      stop = 1'b0;
      base = '0;
      base.illegal = m_ill;
      base.cnt     = m_cnt;
      base.raddr   = m_opnd;
      base.pcn     = p + 11'd1;
      exp_q.push_back(base);             // fetch
      exp_q.push_back(base);             // decode
      if (o == 5'd0) begin
         r = base; r.halted = 1'b1; r.raddr = a;
         for (int i = 0; i < 4; i++) exp_q.push_back(r);
         stop = 1'b1;
         return;
      end
      if (o == 5'd2 || o == 5'd4 || o == 5'd6) begin
         r = base; r.raddr = a; r.rdram = 1'b1;
         exp_q.push_back(r);
         if (abort && o == 5'd6) begin
            stop = 1'b1;
            return;
         end
      end
      r = base; r.raddr = a; r.wrpc = 1'b1;
      case (o)
         5'd1: r.wrram = 1'b1;
         5'd2: begin r.wracc = 1'b1; r.sela = 2'd2; end
         5'd3: begin r.wracc = 1'b1; r.sela = 2'd1; end
         5'd4: r.wracc = 1'b1;
         5'd5: begin r.wracc = 1'b1; r.selb = 1'b1; end
         5'd6: begin r.wracc = 1'b1; r.op = 1'b1; end
         5'd7: begin r.wracc = 1'b1; r.selb = 1'b1; r.op = 1'b1; end
         default: ;
      endcase
      exp_q.push_back(r);
      if (o > 5'd7) m_ill = 1'b1;
      m_cnt  = m_cnt + 16'd1;
      m_opnd = a;
   endtask

   // Cycle-by-cycle compare against the expectation list.
   initial begin
      rec_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle", 64'(actual()), 64'(e));
         end
      end
   end

   // Run from start with reset held on entry; returns in HALT or, with abort, in MEMRD of SUB.
   task automatic run_prog(input logic [10:0] start, input int n_max, input int k_idle, input bit abort);
      bit   stop;
      bit   done;
      rec_t idle_r;
      pc_load = 1'b1; pc_load_val = start;
      @(posedge clk); #1;
      pc_load = 1'b0;
      exp_q.delete();
      m_ill = 1'b0; m_cnt = '0; m_opnd = '0;
      idle_r = '0;
      idle_r.pcn = start + 11'd1;
      for (int i = 0; i <= k_idle; i++) exp_q.push_back(idle_r);
      stop = 1'b0;
      for (int i = 0; i < n_max && !stop; i++) push_instr(start + 11'(i), abort, stop);
      start_bip = (k_idle == 0);
      rst_n = 1'b1;
      for (int j = 0; j < k_idle; j++) begin @(posedge clk); #1; end
      start_bip = 1'b1;
      done = 1'b0;
      for (int j = 0; j < 3000; j++) begin
         @(negedge clk); #1;
         if (exp_q.size() == 0) begin done = 1'b1; break; end
         if (j >= 2) start_bip = 1'($urandom_range(0, 1));
      end
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL run_timeout: actual=%0d pending expected=0", exp_q.size());
      end
   endtask

   task automatic do_reset();
      rec_t r;
      rst_n = 1'b0;
      #1;
      r = actual(); r.pcn = '0;
      chk("reset_outputs", 64'(r), 64'd0);
   endtask

   initial begin
      rec_t r;
      logic [10:0] st;
      int n;
      for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
      rst_n = 1'b0; start_bip = 1'b1; pc_load = 1'b1; pc_load_val = '0;
      repeat (3) begin
         @(negedge clk);
         r = actual(); r.pcn = '0;
         chk("reset_hold", 64'(r), 64'd0);
      end
      pc_load = 1'b0;

      // LDI 5; ADDI 3; STO 0x010; HLT
      rom[0] = {5'd3, 11'h005}; rom[1] = {5'd5, 11'h003};
      rom[2] = {5'd1, 11'h010}; rom[3] = {5'd0, 11'h000};
      run_prog(11'h000, 8, 0, 1'b0);
      chk("prog_count", 64'(instr_count), 64'd3);
      chk("prog_halted", 64'(halted), 64'd1);
      chk("prog_illegal", 64'(illegal), 64'd0);
      do_reset();

      // LD 0x020
      rom[11'h040] = {5'd2, 11'h020}; rom[11'h041] = 16'h0000;
      run_prog(11'h040, 4, 2, 1'b0);
      chk("ld_count", 64'(instr_count), 64'd1);
      do_reset();

      // undefined opcode at pc 7
      rom[7] = {5'b11111, 11'h123}; rom[8] = 16'h0000;
      run_prog(11'h007, 4, 1, 1'b0);
      chk("ill_flag", 64'(illegal), 64'd1);
      chk("ill_pc", 64'(pc_addr), 64'd8);
      chk("ill_count", 64'(instr_count), 64'd1);
      do_reset();

      // PC wrap at top of address space
      rom[11'h7FF] = {5'd5, 11'h001}; rom[0] = 16'h0000;
      run_prog(11'h7FF, 4, 0, 1'b0);
      chk("wrap_pc", 64'(pc_addr), 64'd0);
      chk("wrap_count", 64'(instr_count), 64'd1);
      do_reset();

      // reset during MEMRD of SUB, then clean rerun
      rom[11'h100] = {5'b10110, 11'h0AA}; rom[11'h101] = {5'd3, 11'h009};
      rom[11'h102] = {5'd6, 11'h055};     rom[11'h103] = 16'h0000;
      run_prog(11'h100, 4, 0, 1'b1);
      do_reset();
      @(negedge clk);
      chk("abort_no_wrpc", 64'({WrPC, WrAcc, illegal}), 64'd0);
      chk("abort_count", 64'(instr_count), 64'd0);
      run_prog(11'h100, 4, 0, 1'b0);
      chk("rerun_count", 64'(instr_count), 64'd3);
      chk("rerun_illegal", 64'(illegal), 64'd1);
      do_reset();

      // random programs
      for (int r_i = 0; r_i < 30; r_i++) begin
         st = (r_i % 4 == 0) ? 11'(11'h7FF - $urandom_range(0, 3)) : 11'($urandom_range(0, 2047));
         n  = $urandom_range(1, 12);
         for (int i = 0; i < n - 1; i++) begin
            if ($urandom_range(0, 4) == 0)
               rom[st + 11'(i)] = {5'($urandom_range(8, 31)), 11'($urandom)};
            else
               rom[st + 11'(i)] = {5'($urandom_range(1, 7)), 11'($urandom)};
         end
         rom[st + 11'(n - 1)] = {5'd0, 11'($urandom)};
         run_prog(st, n, $urandom_range(0, 3), 1'b0);
         do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
